// File: rtl/wam_game_core.sv
// wam_game_core: whack-a-mole game engine.
// Runs the SETUP/PLAY/GAME_OVER/RESTART sequence and keeps the score, flick,
// lives, countdown and level counters. Drives load_seed/start_game/clear_n to
// the light and keypad controllers.
// Optional: define WAM_HIGH_SCORE_EN to add the high_score/new_record ports.
//
// state     | meaning
// ----------+----------------------------------------------------------
// SETUP     | after reset, seed loading, waiting for play
// PLAY      | game running, light/key events scored
// GAME_OVER | end condition reached, all counters frozen
// RESTART   | one-cycle clear of submodules before PLAY re-entry
module wam_game_core #(
    parameter int N_LIGHTS      = 9,
    parameter int POS_W         = 4,
    parameter int SCORE_W       = 7,
    parameter int CLK_HZ        = 50_000_000,
    parameter int GAME_SECS     = 60,
    parameter int NORMAL_HITS   = 25,
    parameter int EXTENDED_HITS = 50,
    parameter int LIVES         = 3,
    parameter int LEVEL_STEP    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic [1:0]         mode,
    input  logic               extended,
    input  logic               light_start,
    input  logic               light_end,
    input  logic [POS_W-1:0]   light_pos,
    input  logic               key_valid,
    input  logic [POS_W-1:0]   key,
    output logic [1:0]         state,
    output logic               load_seed,
    output logic               start_game,
    output logic               clear_n,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] flicks,
    output logic [SCORE_W-1:0] max_hits,
    output logic [1:0]         lives_left,
    output logic [5:0]         time_left,
    output logic [1:0]         level,
    output logic               hit_pulse,
    output logic               miss_pulse,
`ifdef WAM_HIGH_SCORE_EN
    output logic               game_over,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record
`else
    output logic               game_over
`endif
);

    typedef enum logic [1:0] {SETUP = 2'd0, PLAY = 2'd1, GAME_OVER = 2'd2, RESTART = 2'd3} state_t;

    localparam logic [1:0]         M_TIMED   = 2'd1;
    localparam logic [1:0]         M_DEATH   = 2'd2;
    localparam logic [1:0]         M_CONT    = 2'd3;
    localparam int                 PS_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0]    PS_MAX    = PS_W'(CLK_HZ - 1);
    localparam logic [POS_W:0]     N_POS     = (POS_W + 1)'(N_LIGHTS);
    localparam logic [SCORE_W-1:0] CNT_MAX   = '1;
    localparam logic [SCORE_W-1:0] STEP_LAST = SCORE_W'(LEVEL_STEP - 1);

    state_t             state_q, state_d;
    logic               play_q;
    logic [1:0]         mode_q, mode_d;
    logic [SCORE_W-1:0] max_hits_q, max_hits_d, score_q, score_d, flicks_q, flicks_d;
    logic [SCORE_W-1:0] step_q, step_d;
    logic [1:0]         lives_q, lives_d, level_q, level_d;
    logic [5:0]         time_q, time_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic               win_open_q, win_open_d, scored_q, scored_d, missed_q, missed_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               hit_pulse_q, miss_pulse_q;

    logic play_rise, in_play, enter_play, end_cond;
    logic key_hit, key_miss, end_miss, miss_evt, open_evt;

    assign play_rise  = play & ~play_q;
    assign in_play    = (state_q == PLAY);
    assign enter_play = (state_d == PLAY) && (state_q != PLAY);

    // A miss by a wrong key does not close the window, so a later correct key
    // still scores; the missed flag stops a second miss in the same window.
    assign key_hit  = in_play & win_open_q & ~scored_q & key_valid & (key == pos_q);
    assign key_miss = in_play & win_open_q & ~scored_q & ~missed_q & key_valid & (key != pos_q);
    assign end_miss = in_play & light_end & win_open_q & ~scored_q & ~key_hit & ~missed_q & ~key_miss;
    assign miss_evt = key_miss | end_miss;
    assign open_evt = in_play & light_start & ({1'b0, light_pos} < N_POS);

    // End condition looks only at registered counters, so GAME_OVER follows one cycle later.
    always_comb begin
        end_cond = (flicks_q == max_hits_q);
        if (mode_q == M_TIMED)      end_cond = (time_q == 6'd0);
        else if (mode_q == M_DEATH) end_cond = (lives_q == 2'd0);
    end

    // Next-state logic; a play edge in PLAY beats the end condition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETUP:     if (play_rise) state_d = PLAY;
            PLAY:      if (play_rise) state_d = RESTART;
                       else if (end_cond) state_d = GAME_OVER;
            GAME_OVER: if (play_rise) state_d = RESTART;
            RESTART:   state_d = PLAY;
            default:   state_d = SETUP;
        endcase
    end

    // Counter and window updates: key first, then light_end, then light_start.
    always_comb begin
        mode_d     = mode_q;
        max_hits_d = max_hits_q;
        score_d    = score_q;
        flicks_d   = flicks_q;
        lives_d    = lives_q;
        time_d     = time_q;
        level_d    = level_q;
        step_d     = step_q;
        ps_d       = ps_q;
        win_open_d = win_open_q;
        scored_d   = scored_q | key_hit;
        missed_d   = missed_q | key_miss;
        pos_d      = pos_q;
        if (enter_play) begin
            mode_d     = mode;
            max_hits_d = extended ? SCORE_W'(EXTENDED_HITS) : SCORE_W'(NORMAL_HITS);
            time_d     = (mode == M_TIMED) ? 6'(GAME_SECS) : 6'd0;
            lives_d    = (mode == M_DEATH) ? 2'(LIVES) : 2'd0;
            score_d    = '0;
            flicks_d   = '0;
            level_d    = 2'd0;
            step_d     = '0;
            ps_d       = '0;
            win_open_d = 1'b0;
            scored_d   = 1'b0;
            missed_d   = 1'b0;
        end else if (in_play) begin
            if (key_hit && score_q != CNT_MAX) begin
                score_d = score_q + 1'b1;
                if (mode_q == M_CONT) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q != 2'd3) level_d = level_q + 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            if (miss_evt && mode_q == M_DEATH && lives_q != 2'd0) lives_d = lives_q - 1'b1;
            if (ps_q == PS_MAX) begin
                ps_d = '0;
                if (time_q != 6'd0) time_d = time_q - 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
            if (light_end) begin
                win_open_d = 1'b0;
                if (flicks_q != CNT_MAX) flicks_d = flicks_q + 1'b1;
            end
            if (open_evt) begin
                win_open_d = 1'b1;
                scored_d   = 1'b0;
                missed_d   = 1'b0;
                pos_d      = light_pos;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SETUP;
            play_q       <= 1'b0;
            mode_q       <= 2'd0;
            max_hits_q   <= '0;
            score_q      <= '0;
            flicks_q     <= '0;
            lives_q      <= 2'd0;
            time_q       <= 6'd0;
            level_q      <= 2'd0;
            step_q       <= '0;
            ps_q         <= '0;
            win_open_q   <= 1'b0;
            scored_q     <= 1'b0;
            missed_q     <= 1'b0;
            pos_q        <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            play_q       <= play;
            mode_q       <= mode_d;
            max_hits_q   <= max_hits_d;
            score_q      <= score_d;
            flicks_q     <= flicks_d;
            lives_q      <= lives_d;
            time_q       <= time_d;
            level_q      <= level_d;
            step_q       <= step_d;
            ps_q         <= ps_d;
            win_open_q   <= win_open_d;
            scored_q     <= scored_d;
            missed_q     <= missed_d;
            pos_q        <= pos_d;
            hit_pulse_q  <= key_hit;
            miss_pulse_q <= miss_evt;
        end
    end

`ifdef WAM_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;
    logic               new_record_q;

    // Record compare uses the score that lands on the edge entering GAME_OVER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_score_q <= '0;
            new_record_q <= 1'b0;
        end else begin
            new_record_q <= 1'b0;
            if (state_q == PLAY && state_d == GAME_OVER && score_d > high_score_q) begin
                high_score_q <= score_d;
                new_record_q <= 1'b1;
            end
        end
    end

    assign high_score = high_score_q;
    assign new_record = new_record_q;
`endif

    assign state      = state_q;
    assign load_seed  = (state_q == SETUP);
    assign start_game = (state_q == PLAY);
    assign clear_n    = (state_q != RESTART);
    assign game_over  = (state_q == GAME_OVER);
    assign score      = score_q;
    assign flicks     = flicks_q;
    assign max_hits   = max_hits_q;
    assign lives_left = lives_q;
    assign time_left  = time_q;
    assign level      = level_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_wam_game_core.sv
// Testbench for wam_game_core (CLK_HZ=10, GAME_SECS=3 for a short countdown).
// Stimulus pushes expected hit/miss/state events into a queue; a monitor pops
// and compares whenever the DUT pulses hit/miss or changes state.
module tb_wam_game_core;

    localparam int K_HIT = 0, K_MISS = 1, K_STATE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       extended = 1'b0;
    logic       light_start = 1'b0, light_end = 1'b0, key_valid = 1'b0;
    logic [3:0] light_pos = 4'd0, key = 4'd0;
    logic [1:0] state, lives_left, level;
    logic       load_seed, start_game, clear_n, hit_pulse, miss_pulse, game_over;
    logic [6:0] score, flicks, max_hits;
    logic [5:0] time_left;
`ifdef WAM_HIGH_SCORE_EN
    logic [6:0] high_score;
    logic       new_record;
`endif

    typedef struct {
        int kind;
        int val;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int failures = 0;
    logic [1:0] prev_state = 2'd0;

    wam_game_core #(.CLK_HZ(10), .GAME_SECS(3)) dut (
        .clk(clk), .reset(reset), .play(play), .mode(mode), .extended(extended),
        .light_start(light_start), .light_end(light_end), .light_pos(light_pos),
        .key_valid(key_valid), .key(key), .state(state), .load_seed(load_seed),
        .start_game(start_game), .clear_n(clear_n), .score(score), .flicks(flicks),
        .max_hits(max_hits), .lives_left(lives_left), .time_left(time_left),
        .level(level), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
`ifdef WAM_HIGH_SCORE_EN
        .game_over(game_over), .high_score(high_score), .new_record(new_record)
`else
        .game_over(game_over)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input int val);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got kind %0d value %0d, nothing expected", kind, val);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL sb_event: got kind %0d value %0d expected kind %0d value %0d",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            if (hit_pulse)           sb_pop(K_HIT, int'(score));
            if (miss_pulse)          sb_pop(K_MISS, int'(lives_left));
            if (state != prev_state) sb_pop(K_STATE, int'(state));
        end
        prev_state = state;
    end

    task automatic step(input logic ls, input logic le, input int pos, input logic kv, input int k);
        light_start = ls;
        light_end   = le;
        light_pos   = 4'(pos);
        key_valid   = kv;
        key         = 4'(k);
        @(posedge clk);
        #1;
        light_start = 1'b0;
        light_end   = 1'b0;
        key_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    // One full window with the matching key; exp_score is the score after the hit.
    task automatic hit_window(input int pos, input int exp_score);
        step(1'b1, 1'b0, pos, 1'b0, 0);
        push(K_HIT, exp_score);
        step(1'b0, 1'b0, 0, 1'b1, pos);
        step(1'b0, 1'b1, 0, 1'b0, 0);
    endtask

    // play edge from PLAY or GAME_OVER: one RESTART cycle, then PLAY.
    task automatic restart_game();
        push(K_STATE, 3);
        push(K_STATE, 1);
        play = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 0);
        chk("restart_state", int'(state), 3);
        chk("restart_clear_n", int'(clear_n), 0);
        play = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 0);
        chk("reentry_state", int'(state), 1);
        chk("reentry_score", int'(score), 0);
        chk("reentry_flicks", int'(flicks), 0);
        chk("reentry_level", int'(level), 0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_load_seed", int'(load_seed), 1);
        chk("rst_start_game", int'(start_game), 0);
        chk("rst_clear_n", int'(clear_n), 1);
        chk("rst_score", int'(score), 0);
        chk("rst_max_hits", int'(max_hits), 0);
        reset = 1'b1;
        idle(2);

        // Normal game: 25 hits end the game
        mode = 2'd0;
        extended = 1'b0;
        push(K_STATE, 1);
        play = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 0);
        play = 1'b0;
        chk("play_state", int'(state), 1);
        chk("play_max_hits", int'(max_hits), 25);
        chk("play_start_game", int'(start_game), 1);
        chk("play_load_seed", int'(load_seed), 0);
        for (int i = 0; i < 25; i++) begin
            if (i == 24) begin
                step(1'b1, 1'b0, i % 9, 1'b0, 0);
                push(K_HIT, 25);
                step(1'b0, 1'b0, 0, 1'b1, i % 9);
                push(K_STATE, 2);
                step(1'b0, 1'b1, 0, 1'b0, 0);
                chk("last_flick_still_play", int'(state), 1);
            end else begin
                hit_window(i % 9, i + 1);
            end
        end
        idle(2);
        chk("normal_score", int'(score), 25);
        chk("normal_flicks", int'(flicks), 25);
        chk("normal_game_over", int'(game_over), 1);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 1'b1, 0);
        step(1'b0, 1'b1, 0, 1'b0, 0);
        chk("frozen_score", int'(score), 25);
        chk("frozen_flicks", int'(flicks), 25);

        // Deathmatch: three unanswered windows
        mode = 2'd2;
        extended = 1'b1;
        restart_game();
        chk("dm_lives", int'(lives_left), 3);
        chk("dm_max_hits", int'(max_hits), 50);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2, 1'b0, 0);
            push(K_MISS, 2 - i);
            if (i == 2) push(K_STATE, 2);
            step(1'b0, 1'b1, 0, 1'b0, 0);
            chk("dm_lives_step", int'(lives_left), 2 - i);
            idle(1);
        end
        idle(1);
        chk("dm_state", int'(state), 2);
        chk("dm_flicks", int'(flicks), 3);

        // Timed: 3 s at 10 cycles per second
        mode = 2'd1;
        extended = 1'b0;
        restart_game();
        chk("timed_load", int'(time_left), 3);
        chk("timed_lives", int'(lives_left), 0);
        idle(29);
        chk("timed_29", int'(time_left), 1);
        idle(1);
        chk("timed_30", int'(time_left), 0);
        chk("timed_30_state", int'(state), 1);
        push(K_STATE, 2);
        idle(1);
        chk("timed_over", int'(state), 2);
        chk("timed_score", int'(score), 0);

        // Window rules in normal mode
        mode = 2'd0;
        restart_game();
        step(1'b1, 1'b0, 4, 1'b0, 0);
        push(K_MISS, 0);
        step(1'b0, 1'b0, 0, 1'b1, 7);
        push(K_HIT, 1);
        step(1'b0, 1'b0, 0, 1'b1, 4);
        step(1'b0, 1'b0, 0, 1'b1, 4);
        step(1'b0, 1'b1, 0, 1'b0, 0);
        chk("wrr_score", int'(score), 1);
        chk("wrr_flicks", int'(flicks), 1);
        step(1'b1, 1'b0, 5, 1'b0, 0);
        push(K_HIT, 2);
        step(1'b0, 1'b1, 0, 1'b1, 5);
        chk("key_with_end_score", int'(score), 2);
        step(1'b1, 1'b0, 6, 1'b0, 0);
        push(K_MISS, 0);
        step(1'b0, 1'b0, 0, 1'b1, 1);
        step(1'b0, 1'b0, 0, 1'b1, 2);
        step(1'b0, 1'b1, 0, 1'b0, 0);
        chk("one_miss_flicks", int'(flicks), 3);
        step(1'b1, 1'b0, 3, 1'b0, 0);
        push(K_MISS, 0);
        step(1'b1, 1'b1, 8, 1'b0, 0);
        push(K_HIT, 3);
        step(1'b0, 1'b0, 0, 1'b1, 8);
        step(1'b0, 1'b1, 0, 1'b0, 0);
        chk("reopen_score", int'(score), 3);
        chk("reopen_flicks", int'(flicks), 5);
        step(1'b1, 1'b0, 9, 1'b0, 0);
        step(1'b0, 1'b0, 0, 1'b1, 9);
        step(1'b0, 1'b1, 0, 1'b0, 0);
        chk("badpos_score", int'(score), 3);
        chk("badpos_flicks", int'(flicks), 6);

        // Mode change mid-game is ignored until re-entry
        mode = 2'd3;
        hit_window(0, 4);
        hit_window(1, 5);
        chk("latched_mode_level", int'(level), 0);

        // Continuity: 12 hits reach level 2
        restart_game();
        for (int i = 0; i < 12; i++) begin
            hit_window(i % 9, i + 1);
            if (i == 3) chk("cont_level_4", int'(level), 0);
            if (i == 4) chk("cont_level_5", int'(level), 1);
        end
        chk("cont_level_12", int'(level), 2);
        chk("cont_score_12", int'(score), 12);
        chk("cont_flicks_12", int'(flicks), 12);
        restart_game();

        // Asynchronous reset mid-game
        hit_window(2, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_load_seed", int'(load_seed), 1);
        idle(2);
        reset = 1'b1;
        idle(2);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending events expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wam_game_core.md
Name: wam_game_core

Overview:
- Parametrised game engine for the whack-a-mole design; successor to the hard-wired top-level game logic.
- Owns the SETUP/PLAY/GAME_OVER/RESTART state machine and the 1 Hz countdown.
- Owns hit/miss scoring, lives, light-flick counting and level progression across N_LIGHTS positions.
- Sits between light_controller/keypad_controller and the HEX decoders; drives their load_seed/start/clear controls.

Parameters:
- N_LIGHTS, 9, number of light/key positions; valid codes are 0..N_LIGHTS-1.
- POS_W, 4, width of light_pos and key codes.
- SCORE_W, 7, width of score, flicks, max_hits.
- CLK_HZ, 50_000_000, clock frequency, used by the 1 Hz prescaler.
- GAME_SECS, 60, timed-mode duration in seconds (max 63).
- NORMAL_HITS, 25, flick limit when extended=0.
- EXTENDED_HITS, 50, flick limit when extended=1.
- LIVES, 3, deathmatch lives (1..3).
- LEVEL_STEP, 5, hits per level advance in continuity mode.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous active-low reset.
- play  in  1  debounced start/restart level; rising edge detected internally.
- mode  in  2  0 normal, 1 timed, 2 deathmatch, 3 continuity.
- extended  in  1  selects EXTENDED_HITS.
- light_start  in  1  1-cycle pulse: light lit at light_pos.
- light_end  in  1  1-cycle pulse: current light turned off.
- light_pos  in  POS_W  position of current light; valid on light_start.
- key_valid  in  1  1-cycle pulse: key press decoded.
- key  in  POS_W  pressed key code.
- state  out  2  0 SETUP, 1 PLAY, 2 GAME_OVER, 3 RESTART.
- load_seed  out  1  high only in SETUP.
- start_game  out  1  high only in PLAY.
- clear_n  out  1  low only in RESTART (active-low clear to submodules).
- score  out  SCORE_W  hits this game.
- flicks  out  SCORE_W  lights completed this game.
- max_hits  out  SCORE_W  latched flick limit.
- lives_left  out  2  remaining lives (deathmatch), else 0.
- time_left  out  6  seconds remaining (timed), else 0.
- level  out  2  current level 0..3.
- hit_pulse  out  1  1-cycle pulse on a scored hit.
- miss_pulse  out  1  1-cycle pulse on a miss.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Reset: state=SETUP; all counters 0; pulses 0; load_seed=1, start_game=0, clear_n=1.
- Control outputs are Moore-decoded from the state register.
- play_rise = play & ~play_q.
- FSM transitions:
  - SETUP -> PLAY on play_rise.
  - PLAY -> RESTART on play_rise; otherwise PLAY -> GAME_OVER on end condition. play_rise wins if both occur in the same cycle.
  - GAME_OVER -> RESTART on play_rise.
  - RESTART -> PLAY unconditionally after 1 cycle.
- Entering PLAY from SETUP or RESTART:
  - latch mode and max_hits; later changes to mode/extended are ignored until the next entry.
  - load time_left=GAME_SECS (timed, else 0) and lives_left=LIVES (deathmatch, else 0).
  - score=flicks=level=0; prescaler=0.
- Window: opens on light_start when light_pos<N_LIGHTS; closes on light_end. Flag scored is cleared at open.
- In PLAY, with the window open and unscored:
  - key_valid with key==light_pos -> score+1 (saturating), hit_pulse, scored=1.
  - key_valid with key!=light_pos -> miss_pulse.
- Further keys in a scored window are ignored. Keys outside any window are ignored.
- light_end with the window unscored -> miss_pulse.
- At most one miss is counted per window.
- light_end -> flicks+1, saturating at all-ones.
- Same-cycle ordering: key_valid is evaluated before light_end, so a key arriving with light_end counts. light_end is processed before light_start in the same cycle (old window closes, new opens).
- Deathmatch: each miss_pulse decrements lives_left, saturating at 0.
- Timed: prescaler counts 0..CLK_HZ-1 in PLAY; at wrap, time_left-1, stopping at 0.
- Continuity: when score reaches a multiple of LEVEL_STEP, level+1, saturating at 3.
- End condition, evaluated in PLAY on registered values, transition the next cycle:
  - normal/continuity: flicks==max_hits.
  - timed: time_left==0.
  - deathmatch: lives_left==0.
- GAME_OVER freezes all counters. Light and key events are ignored outside PLAY.
- Asynchronous reset mid-game returns the block to SETUP immediately.

Optional Feature:
- Macro: WAM_HIGH_SCORE_EN.
- Enabled: extra ports high_score (out, SCORE_W) and new_record (out, 1).
  - On entry to GAME_OVER, if score>high_score: high_score=score and new_record pulses for 1 cycle.
  - high_score is cleared only by reset, not by RESTART.
- Disabled: both ports absent; no extra logic.

Test Plan:
- Reset, play_rise, mode=0, extended=0 -> state=PLAY, max_hits=25; 25 light_start/light_end pairs with matching keys -> score=25, flicks=25, then state=GAME_OVER.
- Deathmatch, LIVES=3: three windows with no key -> 3 miss_pulses, lives_left 3->2->1->0, GAME_OVER on the following cycle.
- Timed, CLK_HZ=10, GAME_SECS=3: 30 PLAY cycles -> time_left=0, GAME_OVER; score unchanged by the timer.
- Within one window press wrong key, then right key, then right key again -> 1 miss_pulse, score=1, flicks=1 after light_end.
- key_valid matching in the same cycle as light_end -> hit counted, no miss_pulse; light_start and light_end in the same cycle -> new window opens.
- Continuity with LEVEL_STEP=5: 12 hits -> level=2; play_rise mid-game -> RESTART for 1 cycle with clear_n=0, then PLAY with all counters 0.
